shiftreg_button_scanner: RTL and testbench
==========================================

# shiftreg_button_scanner

Scans the 16 push-buttons on the Cambridge display board through its external parallel-in/serial-out shift register, debounces them, and presents them to the Clarvi SoC. It sits between the display-board pins (shift clock, active-low load, serial out) and the processor's Avalon-MM bus. It provides a level register, a sticky press-event register and an interrupt.

## Interface
Parameters:
- NBITS, 16, number of shift-register bits (buttons)
- CLK_DIV, 25, `clk` cycles per phase tick; must be ≥4 (25 gives 0.5 µs at 50 MHz)
- SCAN_GAP, 20000, idle ticks between scans; must be ≥1 (≈10 ms scan period at defaults)

Ports:
- clk  in  1  system clock (50 MHz); one clock domain
- reset_n  in  1  reset, asynchronous, active-low
- shiftreg_clk  out  1  shift clock to the board
- shiftreg_loadn  out  1  parallel load to the board, active-low
- shiftreg_out  in  1  serial data from the board; asynchronous, button pressed = 0
- avs_address  in  1  register select
- avs_read  in  1  read strobe
- avs_readdata  out  32  read data, valid one cycle after `avs_read`
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- irq  out  1  high while any event bit is set
- buttons  out  NBITS  debounced level, pressed = 1 (conduit)

## Operation
- **Input synchronizer:** `shiftreg_out` passes through 2 flops. Every sample is taken from the synchronized value and inverted, so pressed reads as 1.
- **Tick generator:** counts 0..CLK_DIV-1 and pulses `tick` for 1 cycle at CLK_DIV-1. Each FSM phase lasts exactly 1 tick.
- **FSM:**
  - LOAD (1 tick): loadn=0, sclk=0. Then go to LOW with bit index = 0.
  - LOW (1 tick): loadn=1, sclk=0. On the phase-ending tick, sample into `shift[NBITS-1-idx]`, so the first bit out becomes the MSB. Then go to HIGH.
  - HIGH (1 tick): sclk=1. On the ending tick: if idx==NBITS-1, go to GAP and raise `scan_done` for 1 cycle; otherwise increment idx and go to LOW.
  - GAP (SCAN_GAP ticks): loadn=1, sclk=0. Then go to LOAD.
- **Debounce (on `scan_done`):**
  - `cand` takes the new scan value.
  - `buttons` takes the new scan value only if the new scan equals `cand`.
  - Net effect: a change must appear in 2 consecutive scans before `buttons` follows it.
- **Events:**
  - `events |= buttons_next & ~buttons` in the cycle `buttons` updates.
  - Writing address 1 clears the bits written as 1 (write-1-to-clear).
  - If a set and a clear hit the same bit in the same cycle, the set wins.
  - `irq = |events`, registered.
- **Register map:**
  - Address 0 reads {zero-pad, buttons}.
  - Address 1 reads {zero-pad, events}.
  - Writes to address 0 are ignored.
  - Reads have no side effects.
- **Reset values:**
  - shiftreg_clk=0, shiftreg_loadn=1.
  - buttons=0, cand=0, events=0, irq=0, avs_readdata=0.
  - FSM in LOAD with tick counter 0, so the first LOAD phase starts on the first cycle after release.
  - Assertion mid-scan aborts the scan; the partial shift data is discarded.

## Timing
- `shiftreg_clk` and `shiftreg_loadn` are driven straight from flops and are glitch-free.
- Scan period = (1 + 2·NBITS + SCAN_GAP)·CLK_DIV cycles.
- Sampling point: end of each LOW phase, i.e. ≥CLK_DIV cycles after the preceding rising edge or load. The 2-cycle synchronizer delay fits because CLK_DIV ≥ 4.
- Latency from a stable input change to `buttons`: the second `scan_done` after the change is captured; `buttons` updates on the cycle after that `scan_done`.
- `events` and `irq` update 1 cycle after `buttons`.
- Avalon read latency is fixed at 1; no waitrequest.
- Write effects are visible on the next cycle.

## Structure
- Package `shiftreg_pkg`:
  - `scan_state_t` enum {LOAD, LOW, HIGH, GAP}
  - `REG_BUTTONS`=1'b0, `REG_EVENTS`=1'b1
- Sub-module `shiftreg_tick`: parameterized CLK_DIV divider producing `tick`.
- Top module contains: synchronizer, FSM, shift/debounce registers, Avalon slave.

## Test plan
Bench parameters for all scenarios: CLK_DIV=4, SCAN_GAP=2, NBITS=16, giving a 140-cycle period. The board model is a behavioural '165.

1. **Reset:** hold reset_n low → sclk=0, loadn=1, irq=0, reads return 0. After release, loadn falls at cycle 1 and stays low 4 cycles; 16 sclk pulses follow, each 4 high / 4 low.
2. **Debounce:** board pattern 16'hFFFE (bit 0 pressed) from t=0 → `buttons`=16'h0000 after scan 1 and 16'h0001 after scan 2. irq rises 1 cycle later; address 1 reads 0x1.
3. **Glitch rejection:** pattern 16'hFF7F (bit 7 pressed) present for only 1 scan → `buttons` never changes, irq stays 0.
4. **Event clear collision:** write 0x1 to address 1 in the same cycle a new press sets bit 0 → bit 0 remains set. A subsequent W1C with no new event clears it and irq falls the next cycle.
5. **Read latency:** read address 0 with all buttons pressed → readdata=0x0000FFFF exactly 1 cycle after avs_read.
6. **Mid-scan reset:** assert reset_n mid-scan at idx=8 → outputs return to reset values immediately. The next full scan starts cleanly with no stale bits.

Source files
------------

// File: rtl/shiftreg_pkg.sv
// rtl/shiftreg_pkg.sv - shared types and register addresses for the button scanner
package shiftreg_pkg;

    typedef enum logic [1:0] {
        LOAD,
        LOW,
        HIGH,
        GAP
    } scan_state_t;

    localparam logic REG_BUTTONS = 1'b0;
    localparam logic REG_EVENTS  = 1'b1;

endpackage

// File: rtl/shiftreg_tick.sv
// rtl/shiftreg_tick.sv - phase tick divider, one-cycle pulse every CLK_DIV clocks
module shiftreg_tick #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/shiftreg_button_scanner.sv
// rtl/shiftreg_button_scanner.sv - scans a PISO button shift register, debounces, Avalon-MM slave
module shiftreg_button_scanner #(
    parameter int NBITS    = 16,
    parameter int CLK_DIV  = 25,
    parameter int SCAN_GAP = 20000
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             shiftreg_clk,
    output logic             shiftreg_loadn,
    input  logic             shiftreg_out,
    input  logic             avs_address,
    input  logic             avs_read,
    output logic [31:0]      avs_readdata,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic             irq,
    output logic [NBITS-1:0] buttons
);
    import shiftreg_pkg::*;

    localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int GW = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NBITS - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(SCAN_GAP - 1);

    scan_state_t     state, state_next;
    logic            tick;
    logic [1:0]      sync_q;
    logic [IW-1:0]   idx;
    logic [GW-1:0]   gap_cnt;
    logic [NBITS-1:0] shift, cand, rise, events, clr_mask, events_next;
    logic            scan_done;
    logic            unused_wdata;

    assign unused_wdata = &{1'b0, avs_writedata[31:NBITS]};

    shiftreg_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (tick) begin
            case (state)
                LOAD:    state_next = LOW;
                LOW:     state_next = HIGH;
                HIGH:    state_next = (idx == IDX_LAST) ? GAP : LOW;
                GAP:     state_next = (gap_cnt == GAP_LAST) ? LOAD : GAP;
                default: state_next = LOAD;
            endcase
        end
    end

    // Pin outputs are registered copies of the phase, so they trail the state by one clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q         <= '1;
            idx            <= '0;
            gap_cnt        <= '0;
            shift          <= '0;
            scan_done      <= 1'b0;
            shiftreg_clk   <= 1'b0;
            shiftreg_loadn <= 1'b1;
        end else begin
            sync_q         <= {sync_q[0], shiftreg_out};
            scan_done      <= 1'b0;
            shiftreg_loadn <= (state != LOAD);
            shiftreg_clk   <= (state == HIGH);
            if (tick) begin
                case (state)
                    LOAD: idx <= '0;
                    LOW:  shift[IDX_LAST - idx] <= ~sync_q[1];
                    HIGH: begin
                        if (idx == IDX_LAST) begin
                            scan_done <= 1'b1;
                            gap_cnt   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    GAP:  gap_cnt <= gap_cnt + 1'b1;
                    default: idx <= '0;
                endcase
            end
        end
    end

    // A new value is accepted only when two consecutive scans agree.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand    <= '0;
            buttons <= '0;
            rise    <= '0;
        end else begin
            rise <= '0;
            if (scan_done) begin
                cand <= shift;
                if (shift == cand) begin
                    buttons <= shift;
                    rise    <= shift & ~buttons;
                end
            end
        end
    end

    // Clear is applied before set so a same-cycle press survives the write.
    always_comb begin
        clr_mask = '0;
        if (avs_write && (avs_address == REG_EVENTS)) begin
            clr_mask = avs_writedata[NBITS-1:0];
        end
        events_next = (events & ~clr_mask) | rise;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            events       <= '0;
            irq          <= 1'b0;
            avs_readdata <= '0;
        end else begin
            events <= events_next;
            irq    <= |events_next;
            if (avs_read) begin
                avs_readdata <= (avs_address == REG_EVENTS) ? 32'(events) : 32'(buttons);
            end
        end
    end

endmodule

// File: tb/tb_shiftreg_button_scanner.sv
// tb/tb_shiftreg_button_scanner.sv - randomized self-checking bench with a scan-level model
module tb_shiftreg_button_scanner;

    localparam int NBITS    = 16;
    localparam int CLK_DIV  = 4;
    localparam int SCAN_GAP = 2;
    localparam int PER      = (1 + 2*NBITS + SCAN_GAP) * CLK_DIV;
    localparam int BTN_P    = (1 + 2*NBITS) * CLK_DIV + 1;
    localparam int EVT_P    = BTN_P + 1;
    localparam int CHG_P    = BTN_P + 3;
    localparam int SCLK_P0  = 1 + 2*CLK_DIV;
    localparam int SCLK_END = SCLK_P0 + 2*NBITS*CLK_DIV - CLK_DIV;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        shiftreg_clk, shiftreg_loadn, shiftreg_out;
    logic        avs_address = 1'b0, avs_read = 1'b0, avs_write = 1'b0;
    logic [31:0] avs_readdata, avs_writedata = '0;
    logic        irq;
    logic [15:0] buttons;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    logic [15:0] board_pattern = 16'hFFFE;
    logic [15:0] sr = '1;

    logic [15:0] m_buttons, m_events, m_cap, m_prev_scan, m_rise, clr_prev;
    logic [31:0] rd_exp;
    bit          rd_prev;

    shiftreg_button_scanner #(.NBITS(NBITS), .CLK_DIV(CLK_DIV), .SCAN_GAP(SCAN_GAP)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .shiftreg_clk   (shiftreg_clk),
        .shiftreg_loadn (shiftreg_loadn),
        .shiftreg_out   (shiftreg_out),
        .avs_address    (avs_address),
        .avs_read       (avs_read),
        .avs_readdata   (avs_readdata),
        .avs_write      (avs_write),
        .avs_writedata  (avs_writedata),
        .irq            (irq),
        .buttons        (buttons)
    );

    always #5 clk = ~clk;

    // Board '165: parallel load on loadn, shift toward QH on sclk rise.
    always @(posedge shiftreg_clk or negedge shiftreg_loadn) begin
        if (!shiftreg_loadn) sr <= board_pattern;
        else                 sr <= {sr[14:0], 1'b1};
    end
    assign shiftreg_out = sr[15];

    always @(posedge clk) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int cyc_of(input int scan, input int phase);
        return scan * PER + phase;
    endfunction

    task automatic model_reset();
        m_buttons = '0; m_events = '0; m_cap = '0; m_prev_scan = '0;
        m_rise = '0; clr_prev = '0; rd_prev = 1'b0; rd_exp = '0;
    endtask

    task automatic goto_cycle(input int c);
        int guard = 0;
        while (cyc < c && guard < 20000) begin
            @(posedge clk); #1;
            guard++;
        end
        check("sequence", cyc, c);
    endtask

    task automatic do_write(input logic addr, input logic [31:0] data);
        avs_address = addr; avs_writedata = data; avs_write = 1'b1;
        @(posedge clk); #1;
        avs_write = 1'b0;
    endtask

    task automatic do_read(input logic addr);
        avs_address = addr; avs_read = 1'b1;
        @(posedge clk); #1;
        avs_read = 1'b0;
    endtask

    // Scan-level model: each scan captures ~pattern at load; two equal scans move buttons.
    always @(negedge clk) begin : cmp
        int   p;
        logic exp_loadn, exp_sclk;
        if (chk_en) begin
            p = cyc % PER;
            m_events = m_events & ~clr_prev;
            if (p == 1) m_cap = ~board_pattern;
            if (p == BTN_P) begin
                if (m_cap == m_prev_scan) begin
                    m_rise    = m_cap & ~m_buttons;
                    m_buttons = m_cap;
                end
                m_prev_scan = m_cap;
            end
            if (p == EVT_P) begin
                m_events = m_events | m_rise;
                m_rise   = '0;
            end
            exp_loadn = !(p >= 1 && p <= CLK_DIV);
            exp_sclk  = (p >= SCLK_P0) && (p < SCLK_END) && (((p - SCLK_P0) % (2*CLK_DIV)) < CLK_DIV);
            check("buttons", 32'(buttons), 32'(m_buttons));
            check("irq", 32'(irq), 32'(|m_events));
            check("loadn", 32'(shiftreg_loadn), 32'(exp_loadn));
            check("sclk", 32'(shiftreg_clk), 32'(exp_sclk));
            if (rd_prev) check("readdata", avs_readdata, rd_exp);
            clr_prev = (avs_write && avs_address) ? avs_writedata[15:0] : 16'h0;
            rd_prev  = avs_read;
            rd_exp   = avs_address ? 32'(m_events) : 32'(m_buttons);
        end
    end

    initial begin
        int r;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sclk", 32'(shiftreg_clk), 32'h0);
        check("rst_loadn", 32'(shiftreg_loadn), 32'h1);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_buttons", 32'(buttons), 32'h0);
        check("rst_readdata", avs_readdata, 32'h0);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        goto_cycle(1);  @(negedge clk); check("loadn_fall", 32'(shiftreg_loadn), 32'h0);
        goto_cycle(4);  @(negedge clk); check("loadn_hold", 32'(shiftreg_loadn), 32'h0);
        goto_cycle(5);  @(negedge clk); check("loadn_rise", 32'(shiftreg_loadn), 32'h1);
        goto_cycle(9);  @(negedge clk); check("sclk_rise", 32'(shiftreg_clk), 32'h1);
        goto_cycle(13); @(negedge clk); check("sclk_fall", 32'(shiftreg_clk), 32'h0);

        goto_cycle(cyc_of(0, BTN_P)); @(negedge clk); check("scan1_buttons", 32'(buttons), 32'h0);
        goto_cycle(cyc_of(1, BTN_P)); @(negedge clk);
        check("scan2_buttons", 32'(buttons), 32'h1);
        check("scan2_irq_lag", 32'(irq), 32'h0);
        goto_cycle(cyc_of(1, EVT_P)); @(negedge clk); check("scan2_irq", 32'(irq), 32'h1);
        goto_cycle(cyc_of(1, EVT_P + 1));
        do_read(1'b1);
        board_pattern = 16'hFF7F;
        @(negedge clk); check("events_read", avs_readdata, 32'h1);

        goto_cycle(cyc_of(2, 0));
        do_write(1'b1, 32'h1);
        @(negedge clk); check("w1c_irq", 32'(irq), 32'h0);
        goto_cycle(cyc_of(2, CHG_P)); board_pattern = 16'hFFFE;
        goto_cycle(cyc_of(4, 0)); @(negedge clk);
        check("glitch_buttons", 32'(buttons), 32'h1);
        check("glitch_irq", 32'(irq), 32'h0);

        goto_cycle(cyc_of(4, CHG_P)); board_pattern = 16'hFFFF;
        goto_cycle(cyc_of(5, 0)); @(negedge clk); check("release_irq", 32'(irq), 32'h0);
        goto_cycle(cyc_of(6, CHG_P)); board_pattern = 16'hFFFE;
        goto_cycle(cyc_of(8, BTN_P));
        do_write(1'b1, 32'h1);
        @(negedge clk);
        check("collide_irq", 32'(irq), 32'h1);
        check("collide_buttons", 32'(buttons), 32'h1);
        goto_cycle(cyc_of(8, EVT_P + 1));
        do_read(1'b1);
        @(negedge clk); check("collide_events", avs_readdata, 32'h1);
        goto_cycle(cyc_of(9, 0));
        do_write(1'b1, 32'h1);
        @(negedge clk); check("clear_irq", 32'(irq), 32'h0);

        goto_cycle(cyc_of(9, CHG_P)); board_pattern = 16'h0000;
        goto_cycle(cyc_of(12, 0));
        do_read(1'b0);
        @(negedge clk); check("read_latency", avs_readdata, 32'h0000FFFF);

        goto_cycle(cyc_of(12, CLK_DIV * 17 + 2));
        chk_en = 1'b0;
        @(negedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("mid_sclk", 32'(shiftreg_clk), 32'h0);
        check("mid_loadn", 32'(shiftreg_loadn), 32'h1);
        check("mid_buttons", 32'(buttons), 32'h0);
        check("mid_irq", 32'(irq), 32'h0);
        check("mid_readdata", avs_readdata, 32'h0);
        board_pattern = 16'hA55A;
        repeat (3) @(posedge clk);
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        chk_en  = 1'b1;
        goto_cycle(cyc_of(0, BTN_P)); @(negedge clk); check("rescan1", 32'(buttons), 32'h0);
        goto_cycle(cyc_of(1, BTN_P)); @(negedge clk); check("rescan2", 32'(buttons), 32'h5AA5);

        for (int c = cyc_of(1, EVT_P); c < cyc_of(31, 0); c++) begin
            goto_cycle(c);
            if (c % PER == CHG_P) begin
                r = $urandom_range(0, 3);
                if (r == 2)      board_pattern = 16'($urandom);
                else if (r == 3) board_pattern = board_pattern ^ (16'h1 << $urandom_range(0, 15));
            end
            avs_read      = 1'b0;
            avs_write     = 1'b0;
            avs_address   = 1'($urandom_range(0, 1));
            avs_writedata = $urandom;
            r = $urandom_range(0, 15);
            if (r < 3)       avs_read  = 1'b1;
            else if (r == 3) avs_write = 1'b1;
        end
        avs_read  = 1'b0;
        avs_write = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
